// File: rtl/reduce_gate_pipe.sv
// Two-stage valid/ready pipelined N-input reduction gate (AND/NAND/OR/NOR/XOR/XNOR)
// for CH independent channels; reserved op codes yield zero with an error flag.
module reduce_gate_pipe #(
    parameter int N_IN = 4,
    parameter int CH   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [CH*N_IN-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH-1:0]        out_y,
    output logic                 out_err
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    logic                 s1_v_q, s1_v_d;
    logic [2:0]           s1_op_q, s1_op_d;
    logic [CH*N_IN-1:0]   s1_data_q, s1_data_d;
    logic                 s2_v_q, s2_v_d;
    logic [CH-1:0]        s2_y_q, s2_y_d;
    logic                 s2_err_q, s2_err_d;

    logic                 s1_adv;
    logic                 s2_adv;
    logic [CH-1:0]        and_r;
    logic [CH-1:0]        or_r;
    logic [CH-1:0]        xor_r;
    logic [CH-1:0]        red_y;
    logic                 red_err;

    // Each channel folds its S1 bits through a chain of 2-input gate primitives.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar i = 0; i < N_IN; i++) begin : g_bit
            wire a_w;
            wire o_w;
            wire x_w;
            if (i == 0) begin : g_first
                assign a_w = s1_data_q[c*N_IN];
                assign o_w = s1_data_q[c*N_IN];
                assign x_w = s1_data_q[c*N_IN];
            end else begin : g_next
                and u_and (a_w, g_bit[i-1].a_w, s1_data_q[c*N_IN+i]);
                or  u_or  (o_w, g_bit[i-1].o_w, s1_data_q[c*N_IN+i]);
                xor u_xor (x_w, g_bit[i-1].x_w, s1_data_q[c*N_IN+i]);
            end
        end
        assign and_r[c] = g_bit[N_IN-1].a_w;
        assign or_r[c]  = g_bit[N_IN-1].o_w;
        assign xor_r[c] = g_bit[N_IN-1].x_w;
    end

    // Op select with optional inversion; reserved codes force zero plus error.
    always_comb begin
        red_y   = {CH{1'b0}};
        red_err = 1'b0;
        case (s1_op_q)
            OP_AND:  red_y = and_r;
            OP_NAND: red_y = ~and_r;
            OP_OR:   red_y = or_r;
            OP_NOR:  red_y = ~or_r;
            OP_XOR:  red_y = xor_r;
            OP_XNOR: red_y = ~xor_r;
            default: begin
                red_y   = {CH{1'b0}};
                red_err = 1'b1;
            end
        endcase
    end

    assign s2_adv   = ~s2_v_q | out_ready;
    assign s1_adv   = ~s1_v_q | s2_adv;
    assign in_ready = s1_adv & ~rst;

    // Next-state for both stages; a stage only moves when the one after it can take data.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_op_d   = s1_op_q;
        s1_data_d = s1_data_q;
        s2_v_d    = s2_v_q;
        s2_y_d    = s2_y_q;
        s2_err_d  = s2_err_q;
        if (s1_adv) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_op_d   = in_op;
                s1_data_d = in_data;
            end else begin
                s1_op_d   = s1_op_q;
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_y_d   = red_y;
                s2_err_d = red_err;
            end else begin
                s2_y_d   = s2_y_q;
                s2_err_d = s2_err_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Pipeline state; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_op_q   <= 3'd0;
            s1_data_q <= {(CH*N_IN){1'b0}};
            s2_v_q    <= 1'b0;
            s2_y_q    <= {CH{1'b0}};
            s2_err_q  <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_op_q   <= s1_op_d;
            s1_data_q <= s1_data_d;
            s2_v_q    <= s2_v_d;
            s2_y_q    <= s2_y_d;
            s2_err_q  <= s2_err_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_y     = s2_y_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Self-checking bench: directed cases on a 4x2 instance, randomized scoreboard run on a 5x3 instance.
module tb_reduce_gate_pipe;

    localparam int AN = 4;
    localparam int AC = 2;
    localparam int BN = 5;
    localparam int BC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [2:0]        a_in_op;
    logic [AC*AN-1:0]  a_in_data;
    logic [AC-1:0]     a_out_y;
    logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [2:0]        b_in_op;
    logic [BC*BN-1:0]  b_in_data;
    logic [BC-1:0]     b_out_y;

    int n_tests = 0;
    int n_fail  = 0;

    reduce_gate_pipe #(.N_IN(AN), .CH(AC)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y), .out_err(a_out_err)
    );

    reduce_gate_pipe #(.N_IN(BN), .CH(BC)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y), .out_err(b_out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: count ones per channel and apply the op rule; error flag lands in bit 16.
    function automatic logic [31:0] ref_red(input logic [2:0] op, input logic [31:0] data,
                                            input int nin, input int ch);
        logic [31:0] r;
        r = 32'd0;
        for (int c = 0; c < ch; c++) begin
            int ones;
            ones = 0;
            for (int i = 0; i < nin; i++) ones += int'(data[c*nin+i]);
            case (op)
                3'd0:    r[c] = (ones == nin);
                3'd1:    r[c] = (ones != nin);
                3'd2:    r[c] = (ones > 0);
                3'd3:    r[c] = (ones == 0);
                3'd4:    r[c] = ((ones % 2) == 1);
                3'd5:    r[c] = ((ones % 2) == 0);
                default: r[c] = 1'b0;
            endcase
        end
        if (op > 3'd5) r[16] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [2:0] op, input logic [7:0] d);
        a_in_valid = v;
        a_in_op    = op;
        a_in_data  = d;
    endtask

    logic [2:0]  t2_ops [5];
    logic [1:0]  t2_exp [5];
    logic [31:0] sb_q [$];
    logic [31:0] exp_v, got_v;
    logic        stall_prev;
    logic [BC-1:0] held_y;
    logic        held_err;

    initial begin
        rst = 1'b1;
        a_drive(1'b0, 3'd0, 8'h00);
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_op = 3'd0; b_in_data = '0; b_out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_y",     32'(a_out_y),     32'd0);
        check("rst_out_err",   32'(a_out_err),   32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(a_in_ready), 32'd1);

        // NAND on F7: channel 0 = 0111, channel 1 = 1111
        a_drive(1'b1, 3'd1, 8'hF7);
        step();
        a_drive(1'b0, 3'd0, 8'h00);
        check("t1_latency_empty", 32'(a_out_valid), 32'd0);
        step();
        check("t1_valid", 32'(a_out_valid), 32'd1);
        check("t1_y",     32'(a_out_y),     32'd1);
        check("t1_err",   32'(a_out_err),   32'd0);

        t2_ops = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd5};
        t2_exp = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) a_drive(1'b1, t2_ops[i], 8'hA5);
            else       a_drive(1'b0, 3'd0, 8'h00);
            step();
            if (i >= 1) begin
                check("t2_valid", 32'(a_out_valid), 32'd1);
                check("t2_y",     32'(a_out_y),     32'(t2_exp[i-1]));
            end
        end
        step();
        check("t2_drained", 32'(a_out_valid), 32'd0);

        // Backpressure: two accepted, third blocked until the consumer releases
        a_out_ready = 1'b0;
        a_drive(1'b1, 3'd0, 8'hFF); #1;
        check("t3_rdy1", 32'(a_in_ready), 32'd1);
        step();
        a_drive(1'b1, 3'd2, 8'h00); #1;
        check("t3_rdy2", 32'(a_in_ready), 32'd1);
        step();
        a_drive(1'b1, 3'd4, 8'h31); #1;
        check("t3_full", 32'(a_in_ready), 32'd0);
        step();
        check("t3_hold_v", 32'(a_out_valid), 32'd1);
        check("t3_hold_y", 32'(a_out_y),     32'd3);
        step();
        check("t3_hold_v2",  32'(a_out_valid), 32'd1);
        check("t3_hold_y2",  32'(a_out_y),     32'd3);
        check("t3_full2",    32'(a_in_ready),  32'd0);
        a_out_ready = 1'b1; #1;
        check("t3_release_rdy", 32'(a_in_ready), 32'd1);
        step();
        a_drive(1'b0, 3'd0, 8'h00);
        check("t3_r2_v", 32'(a_out_valid), 32'd1);
        check("t3_r2_y", 32'(a_out_y),     32'd0);
        step();
        check("t3_r3_v", 32'(a_out_valid), 32'd1);
        check("t3_r3_y", 32'(a_out_y),     32'd1);
        step();
        check("t3_empty", 32'(a_out_valid), 32'd0);

        // Reserved op then a normal op
        a_drive(1'b1, 3'd6, 8'hFF);
        step();
        a_drive(1'b1, 3'd1, 8'hFF);
        step();
        a_drive(1'b0, 3'd0, 8'h00);
        check("t4_res_v",   32'(a_out_valid), 32'd1);
        check("t4_res_y",   32'(a_out_y),     32'd0);
        check("t4_res_err", 32'(a_out_err),   32'd1);
        step();
        check("t4_nand_v",   32'(a_out_valid), 32'd1);
        check("t4_nand_y",   32'(a_out_y),     32'd0);
        check("t4_nand_err", 32'(a_out_err),   32'd0);
        step();

        // Reset with two transactions in flight
        a_drive(1'b1, 3'd0, 8'hFF);
        step();
        a_drive(1'b1, 3'd2, 8'hFF);
        step();
        a_drive(1'b0, 3'd0, 8'h00);
        rst = 1'b1; #1;
        check("t5_rdy_in_rst", 32'(a_in_ready), 32'd0);
        step();
        check("t5_flushed", 32'(a_out_valid), 32'd0);
        rst = 1'b0; #1;
        check("t5_rdy_after", 32'(a_in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_emit", 32'(a_out_valid), 32'd0);
        end

        // Randomized scoreboard run on the 5x3 instance
        stall_prev = 1'b0;
        held_y = '0;
        held_err = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_op     = 3'($urandom_range(0, 7));
            b_in_data   = 15'($urandom);
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                check("b_hold_v",   32'(b_out_valid), 32'd1);
                check("b_hold_y",   32'(b_out_y),     32'(held_y));
                check("b_hold_err", 32'(b_out_err),   32'(held_err));
            end
            check("b_in_ready", 32'(b_in_ready), 32'((sb_q.size() < 2) || b_out_ready));
            if (b_out_valid && b_out_ready) begin
                got_v = 32'd0;
                got_v[BC-1:0] = b_out_y;
                got_v[16] = b_out_err;
                if (sb_q.size() == 0) begin
                    check("b_spurious", got_v, 32'hFFFF_FFFF);
                end else begin
                    exp_v = sb_q.pop_front();
                    check("b_result", got_v, exp_v);
                end
            end
            if (b_in_valid && b_in_ready)
                sb_q.push_back(ref_red(b_in_op, 32'(b_in_data), BN, BC));
            stall_prev = b_out_valid && !b_out_ready;
            held_y   = b_out_y;
            held_err = b_out_err;
            step();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (b_out_valid) begin
                got_v = 32'd0;
                got_v[BC-1:0] = b_out_y;
                got_v[16] = b_out_err;
                if (sb_q.size() == 0) begin
                    check("b_drain_spurious", got_v, 32'hFFFF_FFFF);
                end else begin
                    exp_v = sb_q.pop_front();
                    check("b_drain_result", got_v, exp_v);
                end
            end
            step();
        end
        check("b_drain_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
